gci_irq_controller: RTL and testbench

Per-core interrupt controller between the GCI IRQ lines and the core pipeline's interrupt port. It holds a 64-entry configuration table written by the core's IRQ config-table port (entry, mask, valid, level). It latches rising edges on 64 request lines into pending bits. It picks the highest-priority eligible pending interrupt and offers it on the core's valid/num/ack interrupt handshake.

---
 rtl/gci_irq_controller_if.sv | 32 +++
 rtl/gci_irq_controller.sv | 118 +++++++++++
 tb/tb_gci_irq_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gci_irq_controller_if.sv
// Config-table write port, IRQ request lines and the core interrupt handshake
// between the core pipeline (master) and the per-core IRQ controller (slave).
interface gci_irq_controller_if;
    localparam int unsigned N_LINE = 64;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned LVL_W  = 2;

    logic                 iCONFIG_TABLE_REQ;
    logic [IDX_W-1:0]     iCONFIG_TABLE_ENTRY;
    logic                 iCONFIG_TABLE_FLAG_MASK;
    logic                 iCONFIG_TABLE_FLAG_VALID;
    logic [LVL_W-1:0]     iCONFIG_TABLE_FLAG_LEVEL;
    logic [N_LINE-1:0]    iIRQ_LINE;
    logic                 oINTERRUPT_VALID;
    logic                 iINTERRUPT_ACK;
    logic [IDX_W-1:0]     oINTERRUPT_NUM;
    logic [N_LINE-1:0]    oPENDING;

    modport master (
        output iCONFIG_TABLE_REQ, iCONFIG_TABLE_ENTRY, iCONFIG_TABLE_FLAG_MASK,
               iCONFIG_TABLE_FLAG_VALID, iCONFIG_TABLE_FLAG_LEVEL, iIRQ_LINE,
               iINTERRUPT_ACK,
        input  oINTERRUPT_VALID, oINTERRUPT_NUM, oPENDING
    );

    modport slave (
        input  iCONFIG_TABLE_REQ, iCONFIG_TABLE_ENTRY, iCONFIG_TABLE_FLAG_MASK,
               iCONFIG_TABLE_FLAG_VALID, iCONFIG_TABLE_FLAG_LEVEL, iIRQ_LINE,
               iINTERRUPT_ACK,
        output oINTERRUPT_VALID, oINTERRUPT_NUM, oPENDING
    );
endinterface

// File: rtl/gci_irq_controller.sv
// Per-core interrupt controller: 64-entry config table, rising-edge pending
// latch, level-priority selection and a valid/num/ack offer to the core.
module gci_irq_controller #(
    parameter logic RESET_MASK = 1'b1
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    gci_irq_controller_if.slave  bus
);
    localparam int unsigned N_LINE = 64;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned LVL_W  = 2;

    typedef struct packed {
        logic             mask;
        logic             valid;
        logic [LVL_W-1:0] level;
    } entry_t;

    typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;

    entry_t             tbl [N_LINE];
    logic [N_LINE-1:0]  r_line;
    logic [N_LINE-1:0]  pending;
    logic [N_LINE-1:0]  pending_nxt;
    logic [N_LINE-1:0]  valid_vec;
    logic [N_LINE-1:0]  mask_vec;
    logic [N_LINE-1:0]  line_rise;
    logic [N_LINE-1:0]  ack_clr;
    logic [N_LINE-1:0]  cfg_clr;
    logic [N_LINE-1:0]  eligible;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_num;
    logic [LVL_W-1:0]   sel_lvl;
    state_t             state;
    logic [IDX_W-1:0]   num;

    // Config table: a write replaces all three fields of one entry
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < N_LINE; i++) begin
                tbl[i] <= '{mask: RESET_MASK, valid: 1'b0, level: '0};
            end
        end else if (bus.iCONFIG_TABLE_REQ) begin
            tbl[bus.iCONFIG_TABLE_ENTRY] <= '{mask:  bus.iCONFIG_TABLE_FLAG_MASK,
                                              valid: bus.iCONFIG_TABLE_FLAG_VALID,
                                              level: bus.iCONFIG_TABLE_FLAG_LEVEL};
        end
    end

    // Edge qualification uses the pre-write flags; an invalidating write beats a same-cycle set
    always_comb begin
        valid_vec = '0;
        mask_vec  = '0;
        for (int i = 0; i < N_LINE; i++) begin
            valid_vec[i] = tbl[i].valid;
            mask_vec[i]  = tbl[i].mask;
        end
        line_rise   = bus.iIRQ_LINE & ~r_line;
        ack_clr     = (state == ST_OFFER && bus.iINTERRUPT_ACK) ? (N_LINE'(1) << num) : '0;
        cfg_clr     = (bus.iCONFIG_TABLE_REQ && !bus.iCONFIG_TABLE_FLAG_VALID)
                      ? (N_LINE'(1) << bus.iCONFIG_TABLE_ENTRY) : '0;
        pending_nxt = ((pending & ~ack_clr) | (line_rise & valid_vec)) & ~cfg_clr;
        eligible    = pending & valid_vec & ~mask_vec;
    end

    // Highest level wins; strict compare keeps the lowest index on ties
    always_comb begin
        sel_found = 1'b0;
        sel_num   = '0;
        sel_lvl   = '0;
        for (int i = 0; i < N_LINE; i++) begin
            if (eligible[i] && (!sel_found || tbl[i].level > sel_lvl)) begin
                sel_found = 1'b1;
                sel_num   = IDX_W'(i);
                sel_lvl   = tbl[i].level;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_line  <= '1;
            pending <= '0;
        end else begin
            r_line  <= bus.iIRQ_LINE;
            pending <= pending_nxt;
        end
    end

    // Offer FSM: once offered, the number is held until the core acks
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= ST_IDLE;
            num   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        num   <= sel_num;
                        state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (bus.iINTERRUPT_ACK) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oINTERRUPT_VALID = (state == ST_OFFER);
    assign bus.oINTERRUPT_NUM   = num;
    assign bus.oPENDING         = pending;

endmodule

// File: tb/tb_gci_irq_controller.sv
// Bench for gci_irq_controller: table vectors, directed corner sequences and
// random traffic checked against a rule-level reference model.
module tb_gci_irq_controller;

    typedef struct {
        logic        req;
        logic [5:0]  ent;
        logic        msk;
        logic        vld;
        logic [1:0]  lvl;
        logic [63:0] line;
        logic        ack;
        logic        e_valid;
        logic [5:0]  e_num;
        logic [63:0] e_pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // reference model state
    bit m_mask  [64];
    bit m_valid [64];
    int m_level [64];
    bit m_pend  [64];
    bit m_prev  [64];
    bit m_offer;
    int m_num;

    vec_t vecs [17];

    gci_irq_controller_if bus ();

    gci_irq_controller #(.RESET_MASK(1'b1)) dut (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] bitn(input int n);
        logic [63:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic req, input int ent, input logic msk, input logic vld,
                                input int lvl, input logic [63:0] line, input logic ack,
                                input logic e_valid, input int e_num, input logic [63:0] e_pend);
        vec_t v;
        v.req = req; v.ent = 6'(ent); v.msk = msk; v.vld = vld; v.lvl = 2'(lvl);
        v.line = line; v.ack = ack; v.e_valid = e_valid; v.e_num = 6'(e_num); v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 64; n++) begin
            m_mask[n] = 1'b1; m_valid[n] = 1'b0; m_level[n] = 0;
            m_pend[n] = 1'b0; m_prev[n] = 1'b1;
        end
        m_offer = 1'b0;
        m_num   = 0;
    endtask

    function automatic logic [63:0] m_pend_vec();
        logic [63:0] v;
        for (int n = 0; n < 64; n++) v[n] = m_pend[n];
        return v;
    endfunction

    // Apply one clock edge's worth of rules to the model using the current inputs
    task automatic model_step();
        bit np [64];
        bit found;
        int sel;
        int ent;
        ent = int'(bus.iCONFIG_TABLE_ENTRY);
        for (int n = 0; n < 64; n++) begin
            bit set, aclr, cclr;
            set  = bus.iIRQ_LINE[n] && !m_prev[n] && m_valid[n];
            aclr = m_offer && bus.iINTERRUPT_ACK && (n == m_num);
            cclr = bus.iCONFIG_TABLE_REQ && !bus.iCONFIG_TABLE_FLAG_VALID && (n == ent);
            np[n] = ((m_pend[n] && !aclr) || set) && !cclr;
        end
        if (!m_offer) begin
            found = 1'b0;
            sel   = 0;
            for (int lv = 3; lv >= 0 && !found; lv--)
                for (int n = 0; n < 64 && !found; n++)
                    if (m_pend[n] && m_valid[n] && !m_mask[n] && m_level[n] == lv) begin
                        found = 1'b1;
                        sel   = n;
                    end
            if (found) begin
                m_offer = 1'b1;
                m_num   = sel;
            end
        end else if (bus.iINTERRUPT_ACK) begin
            m_offer = 1'b0;
        end
        for (int n = 0; n < 64; n++) begin
            m_pend[n] = np[n];
            m_prev[n] = bus.iIRQ_LINE[n];
        end
        if (bus.iCONFIG_TABLE_REQ) begin
            m_mask[ent]  = bus.iCONFIG_TABLE_FLAG_MASK;
            m_valid[ent] = bus.iCONFIG_TABLE_FLAG_VALID;
            m_level[ent] = int'(bus.iCONFIG_TABLE_FLAG_LEVEL);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and land #1 after the edge
    task automatic drive(input logic req, input int ent, input logic msk, input logic vld,
                         input int lvl, input logic [63:0] line, input logic ack);
        bus.iCONFIG_TABLE_REQ        = req;
        bus.iCONFIG_TABLE_ENTRY      = 6'(ent);
        bus.iCONFIG_TABLE_FLAG_MASK  = msk;
        bus.iCONFIG_TABLE_FLAG_VALID = vld;
        bus.iCONFIG_TABLE_FLAG_LEVEL = 2'(lvl);
        bus.iIRQ_LINE                = line;
        bus.iINTERRUPT_ACK           = ack;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("model_valid", 64'(bus.oINTERRUPT_VALID), 64'(m_offer));
        chk("model_pending", bus.oPENDING, m_pend_vec());
        if (m_offer) chk("model_num", 64'(bus.oINTERRUPT_NUM), 64'(m_num));
    endtask

    task automatic idle(input logic [63:0] line);
        drive(1'b0, 0, 1'b0, 1'b0, 0, line, 1'b0);
        check_model();
    endtask

    task automatic ack_cyc(input logic [63:0] line);
        drive(1'b0, 0, 1'b0, 1'b0, 0, line, 1'b1);
        check_model();
    endtask

    task automatic cfg(input int ent, input logic msk, input logic vld, input int lvl,
                       input logic [63:0] line);
        drive(1'b1, ent, msk, vld, lvl, line, 1'b0);
        check_model();
    endtask

    initial begin
        logic [63:0] ln;
        rst_n = 1'b0;
        bus.iCONFIG_TABLE_REQ = 1'b0; bus.iCONFIG_TABLE_ENTRY = '0;
        bus.iCONFIG_TABLE_FLAG_MASK = 1'b0; bus.iCONFIG_TABLE_FLAG_VALID = 1'b0;
        bus.iCONFIG_TABLE_FLAG_LEVEL = '0; bus.iIRQ_LINE = '0; bus.iINTERRUPT_ACK = 1'b0;
        model_reset();
        #12;
        chk("reset_valid", 64'(bus.oINTERRUPT_VALID), 64'd0);
        chk("reset_num", 64'(bus.oINTERRUPT_NUM), 64'd0);
        chk("reset_pending", bus.oPENDING, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic delivery on entry 5, then priority ordering 9, 12, 3
        vecs[0]  = mk(1, 5, 0, 1, 2, 64'h0,    0, 0, 0,  64'h0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 64'h20,   0, 0, 0,  64'h20);
        vecs[2]  = mk(0, 0, 0, 0, 0, 64'h20,   0, 1, 5,  64'h20);
        vecs[3]  = mk(0, 0, 0, 0, 0, 64'h20,   0, 1, 5,  64'h20);
        vecs[4]  = mk(0, 0, 0, 0, 0, 64'h20,   1, 0, 0,  64'h0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 64'h0,    0, 0, 0,  64'h0);
        vecs[6]  = mk(1, 3, 0, 1, 1, 64'h0,    0, 0, 0,  64'h0);
        vecs[7]  = mk(1, 9, 0, 1, 3, 64'h0,    0, 0, 0,  64'h0);
        vecs[8]  = mk(1, 12, 0, 1, 3, 64'h0,   0, 0, 0,  64'h0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 64'h1208, 0, 0, 0,  64'h1208);
        vecs[10] = mk(0, 0, 0, 0, 0, 64'h1208, 0, 1, 9,  64'h1208);
        vecs[11] = mk(0, 0, 0, 0, 0, 64'h1208, 1, 0, 0,  64'h1008);
        vecs[12] = mk(0, 0, 0, 0, 0, 64'h1208, 0, 1, 12, 64'h1008);
        vecs[13] = mk(0, 0, 0, 0, 0, 64'h1208, 1, 0, 0,  64'h0008);
        vecs[14] = mk(0, 0, 0, 0, 0, 64'h1208, 0, 1, 3,  64'h0008);
        vecs[15] = mk(0, 0, 0, 0, 0, 64'h1208, 1, 0, 0,  64'h0);
        vecs[16] = mk(0, 0, 0, 0, 0, 64'h0,    0, 0, 0,  64'h0);
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].req, int'(vecs[i].ent), vecs[i].msk, vecs[i].vld,
                  int'(vecs[i].lvl), vecs[i].line, vecs[i].ack);
            chk($sformatf("vec%0d_valid", i), 64'(bus.oINTERRUPT_VALID), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d_pending", i), bus.oPENDING, vecs[i].e_pend);
            if (vecs[i].e_valid)
                chk($sformatf("vec%0d_num", i), 64'(bus.oINTERRUPT_NUM), 64'(vecs[i].e_num));
        end

        // masked entry latches but is not offered until unmasked
        cfg(7, 1, 1, 0, 64'h0);
        idle(bitn(7));
        idle(bitn(7));
        chk("mask_pending7", 64'(bus.oPENDING[7]), 64'd1);
        chk("mask_no_offer", 64'(bus.oINTERRUPT_VALID), 64'd0);
        cfg(7, 0, 1, 0, 64'h0);
        idle(64'h0);
        chk("unmask_valid", 64'(bus.oINTERRUPT_VALID), 64'd1);
        chk("unmask_num", 64'(bus.oINTERRUPT_NUM), 64'd7);
        ack_cyc(64'h0);
        cfg(7, 1, 1, 0, 64'h0);
        idle(bitn(7));
        idle(64'h0);
        chk("remask_pending7", 64'(bus.oPENDING[7]), 64'd1);
        cfg(7, 0, 0, 0, 64'h0);
        chk("invalidate_pending7", 64'(bus.oPENDING[7]), 64'd0);
        idle(64'h0);
        idle(64'h0);
        chk("invalidate_no_offer", 64'(bus.oINTERRUPT_VALID), 64'd0);

        // edge in the ack cycle re-arms the same entry
        cfg(4, 0, 1, 1, 64'h0);
        idle(bitn(4));
        idle(64'h0);
        chk("coll_offer4", 64'(bus.oINTERRUPT_NUM), 64'd4);
        ack_cyc(bitn(4));
        chk("coll_ack_valid", 64'(bus.oINTERRUPT_VALID), 64'd0);
        chk("coll_pending4", 64'(bus.oPENDING[4]), 64'd1);
        idle(64'h0);
        chk("coll_reoffer_valid", 64'(bus.oINTERRUPT_VALID), 64'd1);
        chk("coll_reoffer_num", 64'(bus.oINTERRUPT_NUM), 64'd4);
        ack_cyc(64'h0);

        // invalidating write beats a same-cycle edge
        cfg(6, 1, 1, 0, 64'h0);
        cfg(6, 0, 0, 0, bitn(6));
        chk("edge_vs_invalidate", 64'(bus.oPENDING[6]), 64'd0);
        idle(64'h0);

        // offer is never withdrawn nor pre-empted
        cfg(2, 0, 1, 0, 64'h0);
        cfg(10, 0, 1, 3, 64'h0);
        idle(bitn(2));
        idle(64'h0);
        chk("stable_num_a", 64'(bus.oINTERRUPT_NUM), 64'd2);
        cfg(2, 1, 1, 0, bitn(10));
        idle(bitn(10));
        idle(bitn(10));
        chk("stable_valid", 64'(bus.oINTERRUPT_VALID), 64'd1);
        chk("stable_num_b", 64'(bus.oINTERRUPT_NUM), 64'd2);
        ack_cyc(64'h0);
        idle(64'h0);
        chk("next_num10", 64'(bus.oINTERRUPT_NUM), 64'd10);
        ack_cyc(64'h0);

        // ack while idle is ignored
        idle(64'h0);
        ack_cyc(64'h0);
        chk("spurious_ack_valid", 64'(bus.oINTERRUPT_VALID), 64'd0);
        idle(64'h0);

        // asynchronous reset in the middle of an offer
        idle(bitn(4));
        idle(64'h0);
        chk("pre_reset_valid", 64'(bus.oINTERRUPT_VALID), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.oINTERRUPT_VALID), 64'd0);
        chk("async_rst_num", 64'(bus.oINTERRUPT_NUM), 64'd0);
        chk("async_rst_pending", bus.oPENDING, 64'd0);
        model_reset();
        bus.iIRQ_LINE = bitn(20);
        bus.iINTERRUPT_ACK = 1'b0;
        bus.iCONFIG_TABLE_REQ = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cfg(20, 0, 1, 3, bitn(20));
        idle(bitn(20));
        idle(bitn(20));
        chk("held_line_no_pending", 64'(bus.oPENDING[20]), 64'd0);
        chk("held_line_no_offer", 64'(bus.oINTERRUPT_VALID), 64'd0);

        // random traffic against the model
        ln = bitn(20);
        for (int c = 0; c < 2000; c++) begin
            logic [63:0] tg;
            logic        rq;
            tg = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            ln = ln ^ tg;
            rq = ($urandom_range(0, 5) == 0);
            drive(rq, int'($urandom_range(0, 63)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)), ln,
                  1'($urandom_range(0, 2) == 0));
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
